ysyx_22050612_ifu: RTL and testbench

Instruction fetch unit for the ysyx_22050612 core. It sits directly upstream of the decode stage. It holds the fetch PC, issues one 32-bit instruction read at a time over a valid/ready request and response memory port, and presents the fetched word with its PC to decode over a valid/ready handshake. It also accepts PC redirects from the execute stage and kills any wrong-path fetch in flight.

---
 rtl/ysyx_22050612_ifu_pkg.sv | 34 +++
 rtl/ysyx_22050612_ifu.sv | 176 +++++++++++++++++
 tb/tb_ysyx_22050612_ifu.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050612_ifu_pkg.sv
// Shared definitions for the ysyx_22050612 fetch unit: data widths, the
// default boot address, the fetch FSM state type and small PC helpers.
package ysyx_22050612_ifu_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // First fetch address after reset unless the top overrides it.
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  // Fetch FSM states.
  //   FETCH_IDLE : only entered from reset, leaves after one cycle
  //   FETCH_REQ  : presenting a read request (or a misaligned-PC fault)
  //   FETCH_WAIT : one read outstanding, waiting for the response pulse
  //   FETCH_HOLD : instruction presented to decode until accepted
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_e;

  // Instructions are 32-bit and must sit on a 4-byte boundary; only the two
  // low PC bits decide alignment.
  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return (pc_lo != 2'b00);
  endfunction

  // Sequential successor of a PC; wraps naturally at 2^64.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: holds the fetch PC, issues one instruction read at
// a time, presents the fetched word and its PC to decode, and squashes
// wrong-path fetches when execute redirects the PC.
module ysyx_22050612_ifu
  import ysyx_22050612_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  // redirect from execute (branch, jump, trap); wins over everything else
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  // instruction memory request channel
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  // instruction memory response channel (single-cycle pulse)
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  // decode channel
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic        out_fault,
  output logic [63:0] fetch_count
);

  // Architectural state of the fetch unit.
  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d;
  logic [ILEN-1:0]   out_inst_q, out_inst_d;
  logic              out_fault_q, out_fault_d;
  logic [XLEN-1:0]   fetch_count_q, fetch_count_d;

  // Handshake events for the current cycle.
  logic pc_bad;
  logic req_fire;
  logic out_fire;

  // A misaligned PC never reaches memory; the request line only looks at
  // registered state and PC so memory never sees a path from its own inputs.
  assign pc_bad         = pc_misaligned(pc_q[1:0]);
  assign imem_req_valid = (state_q == FETCH_REQ) && !pc_bad;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Decode sees only registered values.
  assign out_valid   = (state_q == FETCH_HOLD);
  assign out_inst    = out_inst_q;
  assign out_pc      = out_pc_q;
  assign out_fault   = out_fault_q;
  assign fetch_count = fetch_count_q;

  // A redirect in the same cycle cancels the hand-off to decode.
  assign out_fire = out_valid && out_ready && !redirect_valid;

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    out_pc_d      = out_pc_q;
    out_inst_d    = out_inst_q;
    out_fault_d   = out_fault_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      FETCH_IDLE: begin
        // Always move on to fetching; an early redirect just changes where.
        state_d = FETCH_REQ;
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else begin
          pc_d = pc_q;
        end
      end

      FETCH_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (req_fire) begin
            // The old-path read is already on its way; remember to drop it.
            out_pc_d = pc_q;
            kill_d   = 1'b1;
            state_d  = FETCH_WAIT;
          end else begin
            state_d = FETCH_REQ;
          end
        end else if (pc_bad) begin
          // Report the misaligned fetch to decode without touching memory.
          out_pc_d    = pc_q;
          out_inst_d  = {ILEN{1'b0}};
          out_fault_d = 1'b1;
          state_d     = FETCH_HOLD;
        end else if (req_fire) begin
          out_pc_d = pc_q;
          state_d  = FETCH_WAIT;
        end else begin
          state_d = FETCH_REQ;
        end
      end

      FETCH_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_resp_valid) begin
            // Wrong-path data arrives right now: drop it, nothing left in flight.
            kill_d  = 1'b0;
            state_d = FETCH_REQ;
          end else begin
            // Data still in flight: mark it for discard when it lands.
            kill_d  = 1'b1;
            state_d = FETCH_WAIT;
          end
        end else if (imem_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = FETCH_REQ;
          end else begin
            out_inst_d  = imem_resp_err ? {ILEN{1'b0}} : imem_resp_data;
            out_fault_d = imem_resp_err;
            state_d     = FETCH_HOLD;
          end
        end else begin
          state_d = FETCH_WAIT;
        end
      end

      FETCH_HOLD: begin
        if (redirect_valid) begin
          // Held instruction is on the wrong path; it is neither delivered
          // nor counted.
          pc_d    = redirect_pc;
          state_d = FETCH_REQ;
        end else if (out_fire) begin
          pc_d          = next_seq_pc(out_pc_q);
          fetch_count_d = fetch_count_q + 64'd1;
          state_d       = FETCH_REQ;
        end else begin
          state_d = FETCH_HOLD;
        end
      end

      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      out_pc_q      <= {XLEN{1'b0}};
      out_inst_q    <= {ILEN{1'b0}};
      out_fault_q   <= 1'b0;
      fetch_count_q <= {XLEN{1'b0}};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      out_pc_q      <= out_pc_d;
      out_inst_q    <= out_inst_d;
      out_fault_q   <= out_fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Self-checking bench for ysyx_22050612_ifu: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model of the
// fetch stream (next expected PC, memory contents, delivered count).
module tb_ysyx_22050612_ifu;
  import ysyx_22050612_ifu_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_fault;
  logic [63:0] fetch_count;

  int tests;
  int fails;

  // Reference model state.
  logic [63:0] exp_pc;      // PC of the next instruction decode should see
  logic [63:0] exp_count;   // instructions delivered so far
  bit          mem_busy;    // memory holds an accepted request
  int          mem_lat;     // idle cycles left before the response pulse
  logic [63:0] mem_addr;
  int          next_lat;    // latency given to the next accepted request
  int          cyc_n;
  int          deliv_cyc[$];

  ysyx_22050612_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .out_fault       (out_fault),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Pages with address bits [15:12] == 0xE raise an access fault.
  function automatic logic err_at(input logic [63:0] a);
    return (a[15:12] == 4'hE);
  endfunction

  function automatic logic fault_at(input logic [63:0] a);
    return (a[1:0] != 2'b00) || err_at(a);
  endfunction

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return fault_at(a) ? 32'h0 : inst_of(a);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the falling edge, check the
  // transfers that the coming rising edge will perform, advance the memory
  // model, then check the delivered count after the edge.
  task automatic cyc(input logic rr, input logic ordy, input logic rv, input logic [63:0] rpc);
    logic        req_fire;
    logic        out_fire;
    logic        resp_now;
    logic [63:0] req_addr_s;
    imem_req_ready  = rr;
    out_ready       = ordy;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    resp_now        = mem_busy && (mem_lat == 0);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? inst_of(mem_addr) : 32'h0;
    imem_resp_err   = resp_now ? err_at(mem_addr) : 1'b0;
    #1;
    req_fire   = imem_req_valid && rr;
    out_fire   = out_valid && ordy && !rv;
    req_addr_s = imem_req_addr;
    if (!rst) begin
      if (req_fire) begin
        chk1("one_outstanding", mem_busy, 1'b0);
        if (!rv) chk64("req_addr", req_addr_s, exp_pc);
      end
      if (out_fire) begin
        chk64("deliv_pc", out_pc, exp_pc);
        chk32("deliv_inst", out_inst, word_at(exp_pc));
        chk1("deliv_fault", out_fault, fault_at(exp_pc));
        exp_pc    = exp_pc + 64'd4;
        exp_count = exp_count + 64'd1;
        deliv_cyc.push_back(cyc_n);
      end
      if (rv) exp_pc = rpc;
    end
    @(posedge clk);
    if (resp_now) mem_busy = 1'b0;
    else if (mem_busy) mem_lat--;
    if (req_fire) begin
      mem_busy = 1'b1;
      mem_lat  = next_lat;
      mem_addr = req_addr_s;
    end
    if (rst) begin
      exp_pc    = RST_PC;
      exp_count = 64'd0;
    end
    cyc_n++;
    @(negedge clk);
    chk64("fetch_count", fetch_count, exp_count);
  endtask

  initial begin
    int d0, d1, d2;
    logic        rnd_rv;
    logic [63:0] rnd_pc;
    logic [31:0] rnd_bits;
    tests = 0; fails = 0;
    exp_pc = RST_PC; exp_count = 64'd0;
    mem_busy = 1'b0; mem_lat = 0; mem_addr = 64'd0; next_lat = 0; cyc_n = 0;
    rst = 1'b1; imem_req_ready = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 64'd0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0; imem_resp_err = 1'b0;

    // Reset state.
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 64'd0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk64("rst_out_pc", out_pc, 64'd0);
    chk32("rst_out_inst", out_inst, 32'h0);
    chk1("rst_out_fault", out_fault, 1'b0);

    // Release reset: one IDLE cycle, then a 3-cycle fetch period.
    rst = 1'b0; cyc_n = 0; deliv_cyc.delete();
    chk1("idle_no_req", imem_req_valid, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 64'd0);
    chk1("first_req_valid", imem_req_valid, 1'b1);
    chk64("first_req_addr", imem_req_addr, RST_PC);
    repeat (9) cyc(1'b1, 1'b1, 1'b0, 64'd0);
    d0 = (deliv_cyc.size() > 0) ? deliv_cyc[0] : -1;
    d1 = (deliv_cyc.size() > 1) ? deliv_cyc[1] : -1;
    d2 = (deliv_cyc.size() > 2) ? deliv_cyc[2] : -1;
    chk32("boot_deliveries", deliv_cyc.size(), 32'd3);
    chk32("boot_first_cycle", d0, 32'd3);
    chk32("boot_period_a", d1 - d0, 32'd3);
    chk32("boot_period_b", d2 - d1, 32'd3);
    chk64("boot_count", fetch_count, 64'd3);

    // Decode stalls for 5 cycles in HOLD.
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk1("stall_valid", out_valid, 1'b1);
      chk64("stall_pc", out_pc, 64'h8000_000C);
      chk32("stall_inst", out_inst, inst_of(64'h8000_000C));
      chk1("stall_no_req", imem_req_valid, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 64'd0);
    end
    cyc(1'b1, 1'b1, 1'b0, 64'd0);
    chk1("after_stall_req", imem_req_valid, 1'b1);
    chk64("after_stall_addr", imem_req_addr, 64'h8000_0010);

    // Redirect while waiting; stale response lands 4 cycles later.
    next_lat = 4;
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 64'h8000_1000);
    for (int i = 0; i < 4; i++) begin
      chk1("kill_wait_valid", out_valid, 1'b0);
      chk1("kill_wait_noreq", imem_req_valid, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 64'd0);
    end
    next_lat = 0;
    chk1("kill_dropped", out_valid, 1'b0);
    chk1("kill_req_valid", imem_req_valid, 1'b1);
    chk64("kill_req_addr", imem_req_addr, 64'h8000_1000);
    chk64("kill_count", fetch_count, 64'd4);

    // Redirect in the same cycle as the response.
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 64'h8000_2000);
    chk1("samecyc_dropped", out_valid, 1'b0);
    chk1("samecyc_req_valid", imem_req_valid, 1'b1);
    chk64("samecyc_req_addr", imem_req_addr, 64'h8000_2000);

    // Redirect in HOLD with decode ready.
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 64'd0);
    chk1("hold_valid", out_valid, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 64'h8000_3000);
    chk1("hold_redir_valid", out_valid, 1'b0);
    chk1("hold_redir_req", imem_req_valid, 1'b1);
    chk64("hold_redir_addr", imem_req_addr, 64'h8000_3000);
    chk64("hold_redir_count", fetch_count, 64'd4);

    // Misaligned redirect target.
    cyc(1'b0, 1'b0, 1'b1, 64'h8000_0002);
    chk1("misal_no_req", imem_req_valid, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    chk1("misal_valid", out_valid, 1'b1);
    chk1("misal_fault", out_fault, 1'b1);
    chk32("misal_inst", out_inst, 32'h0);
    chk64("misal_pc", out_pc, 64'h8000_0002);
    cyc(1'b0, 1'b1, 1'b0, 64'd0);

    // Access fault from memory.
    cyc(1'b0, 1'b0, 1'b1, 64'h8000_E000);
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 64'd0);
    chk1("err_valid", out_valid, 1'b1);
    chk1("err_fault", out_fault, 1'b1);
    chk32("err_inst", out_inst, 32'h0);
    chk64("err_pc", out_pc, 64'h8000_E000);
    cyc(1'b0, 1'b1, 1'b0, 64'd0);
    chk64("err_count", fetch_count, 64'd6);

    // Reset pulse while a read is outstanding; stale response arrives in REQ.
    next_lat = 3;
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 64'd0);
    chk1("midrst_valid", out_valid, 1'b0);
    chk1("midrst_req", imem_req_valid, 1'b0);
    chk64("midrst_count", fetch_count, 64'd0);
    rst = 1'b0; next_lat = 0;
    cyc(1'b0, 1'b0, 1'b0, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 64'd0);
    chk1("stale_ignored", out_valid, 1'b0);
    chk1("stale_req_valid", imem_req_valid, 1'b1);
    chk64("stale_req_addr", imem_req_addr, RST_PC);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 64'd0);
    chk64("restart_count", fetch_count, 64'd1);

    // Randomized traffic: ready, latency and redirects all vary.
    deliv_cyc.delete();
    for (int i = 0; i < 3000; i++) begin
      next_lat = $urandom_range(0, 3);
      rnd_bits = $urandom;
      rnd_rv   = ($urandom_range(0, 15) == 0);
      rnd_pc   = {32'h0000_0000, 16'h8000, rnd_bits[15:2],
                  (($urandom_range(0, 7) == 0) ? rnd_bits[17:16] : 2'b00)};
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rnd_rv, rnd_pc);
    end
    chk1("random_progress", (deliv_cyc.size() > 100), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
